// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor built around a single full-adder
// cell that is reused for WIDTH clock cycles, LSB first, with a registered
// carry between steps.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  operation request, sampled only while busy=0
//   a, b   operands, captured on an accepted start
//   cin    carry-in for add mode, captured on an accepted start
//   sub    mode: 0 = a+b+cin, 1 = a-b (a + ~b + 1)
//   busy   high while the serial steps are running
//   done   one-cycle pulse when sum/cout/ovf are refreshed
//   sum    result, held from one done pulse until the next
//   cout   carry out of the MSB (in subtract mode 1 = no borrow)
//   ovf    two's-complement overflow (carry into MSB xor carry out of MSB)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH:0]   acc_shift;
  logic             last_step;

  // The one full-adder cell, fed by the operand LSBs and the carry register.
  assign fa_s = opa[0] ^ opb[0] ^ carry;
  assign fa_c = (opa[0] & opb[0]) | (carry & (opa[0] ^ opb[0]));

  // New sum bit enters from the MSB side; dropping bit 0 of the concatenation
  // gives the shifted result and also works for WIDTH=1.
  assign acc_shift = {fa_s, acc};
  assign last_step = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        // A start in the done cycle is taken immediately (back-to-back).
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
      opa   <= a;
      opb   <= sub ? ~b : b;
      carry <= sub | cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      opa   <= opa >> 1;
      opb   <= opb >> 1;
      carry <= fa_c;
      cnt   <= cnt + CW'(1);
      acc   <= acc_shift[WIDTH:1];
      if (last_step) begin
        // On the MSB step the carry register holds the carry into the MSB.
        sum  <= acc_shift[WIDTH:1];
        cout <= fa_c;
        ovf  <= carry ^ fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder. One WIDTH=8 instance
// covers timing, handshake, reset and random arithmetic; a WIDTH=2 instance
// is swept over every operand/mode combination. Expected results come from
// plain integer arithmetic on the operands.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start8, cin8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, sub2, busy2, done2, cout2, ovf2;
  logic [1:0] a2, b2, sum2;

  int chk_cnt;
  int pass_cnt;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .sub(sub8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .ovf(ovf8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .sub(sub2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2),
    .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: unsigned sum/carry from integer addition, overflow from the
  // signed value of the same operation falling outside the W-bit range.
  function automatic void model(input int w, input longint ua, input longint ub,
                                input bit c, input bit s, output longint es,
                                output bit eco, output bit eov);
    longint mask, full, sa, sb, r;
    mask = (longint'(1) << w) - 1;
    full = s ? (ua + ((~ub) & mask) + 1) : (ua + ub + longint'(c));
    es   = full & mask;
    eco  = ((full >> w) & 1) != 0;
    sa   = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
    sb   = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
    r    = s ? (sa - sb) : (sa + sb + longint'(c));
    eov  = (r > ((longint'(1) << (w - 1)) - 1)) || (r < -(longint'(1) << (w - 1)));
  endfunction

  // Drives a start on the WIDTH=8 DUT right now (caller sits just after a
  // falling edge), then follows it until done. lat = falling edges after the
  // accepting rising edge at which done was seen (-1 on timeout).
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                     input logic is, output int lat, output int nbusy);
    a8 = ia; b8 = ib; cin8 = ic; sub8 = is; start8 = 1'b1;
    lat = -1; nbusy = 0;
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (busy8) nbusy++;
      if (done8) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic op2(input logic [1:0] ia, input logic [1:0] ib, input logic ic,
                     input logic is, output int lat);
    a2 = ia; b2 = ib; cin2 = ic; sub2 = is; start2 = 1'b1;
    lat = -1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (done2) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'd0) begin
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy8, done8, sum8, cout8, ovf8);
    end else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy8, done8);
    end else pass_cnt++;
  endtask

  task automatic test_latency();
    int lat, nb;
    logic [7:0] held;
    op8(8'h5A, 8'h3C, 1'b0, 1'b0, lat, nb);
    chk_cnt++;
    if (lat !== 9) $display("FAIL latency: got %0d, want 9", lat); else pass_cnt++;
    chk_cnt++;
    if (nb !== 8) $display("FAIL busy_cycles: got %0d, want 8", nb); else pass_cnt++;
    chk_cnt++;
    if ({sum8, cout8, ovf8} !== {8'h96, 1'b0, 1'b1}) begin
      $display("FAIL add_5a_3c: got sum=%h cout=%b ovf=%b, want 96 0 1", sum8, cout8, ovf8);
    end else pass_cnt++;
    held = sum8;
    @(negedge clk);
    chk_cnt++;
    if (done8 !== 1'b0) $display("FAIL done_pulse_width: got done=%b, want 0", done8);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (sum8 !== held || busy8 !== 1'b0) begin
      $display("FAIL idle_hold: got sum=%h busy=%b, want %h 0", sum8, busy8, held);
    end else pass_cnt++;
  endtask

  task automatic test_carry_sub();
    int lat, nb;
    op8(8'hFF, 8'h01, 1'b1, 1'b0, lat, nb);
    chk_cnt++;
    if (lat !== 9 || {sum8, cout8, ovf8} !== {8'h01, 1'b1, 1'b0}) begin
      $display("FAIL add_ff_01_c1: got lat=%0d sum=%h cout=%b ovf=%b, want 9 01 1 0",
               lat, sum8, cout8, ovf8);
    end else pass_cnt++;
    @(negedge clk);
    // cin=1 must be ignored in subtract mode.
    op8(8'h10, 8'h20, 1'b1, 1'b1, lat, nb);
    chk_cnt++;
    if (lat !== 9 || {sum8, cout8, ovf8} !== {8'hF0, 1'b0, 1'b0}) begin
      $display("FAIL sub_10_20: got lat=%0d sum=%h cout=%b ovf=%b, want 9 f0 0 0",
               lat, sum8, cout8, ovf8);
    end else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    op8(8'h80, 8'h01, 1'b0, 1'b1, lat, nb);
    chk_cnt++;
    if (lat !== 9 || {sum8, cout8, ovf8} !== {8'h7F, 1'b1, 1'b1}) begin
      $display("FAIL sub_80_01: got lat=%0d sum=%h cout=%b ovf=%b, want 9 7f 1 1",
               lat, sum8, cout8, ovf8);
    end else pass_cnt++;
    // Start raised during the done cycle.
    op8(8'h01, 8'h01, 1'b0, 1'b0, lat, nb);
    chk_cnt++;
    if (lat !== 9 || nb !== 8 || {sum8, cout8, ovf8} !== {8'h02, 1'b0, 1'b0}) begin
      $display("FAIL back_to_back: got lat=%0d busy=%0d sum=%h cout=%b ovf=%b, want 9 8 02 0 0",
               lat, nb, sum8, cout8, ovf8);
    end else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int dones, lat;
    a8 = 8'h21; b8 = 8'h13; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    dones = 0; lat = -1;
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 3) begin
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; sub8 = 1'b1; start8 = 1'b1;
      end
      if (k == 4) start8 = 1'b0;
      if (done8) begin
        dones++;
        if (lat < 0) lat = k;
        chk_cnt++;
        if (sum8 !== 8'h34 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
          $display("FAIL ignore_start_result: got sum=%h cout=%b ovf=%b, want 34 0 0",
                   sum8, cout8, ovf8);
        end else pass_cnt++;
      end
    end
    chk_cnt++;
    if (dones !== 1 || lat !== 9) begin
      $display("FAIL ignore_start_dones: got dones=%0d lat=%0d, want 1 9", dones, lat);
    end else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int dones, lat, nb;
    a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'd0) begin
      $display("FAIL async_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy8, done8, sum8, cout8, ovf8);
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done8 || busy8) dones++;
    end
    chk_cnt++;
    if (dones !== 0 || sum8 !== 8'h00) begin
      $display("FAIL reset_abandon: got active_cycles=%0d sum=%h, want 0 00", dones, sum8);
    end else pass_cnt++;
    op8(8'h0C, 8'h07, 1'b1, 1'b0, lat, nb);
    chk_cnt++;
    if (lat !== 9 || {sum8, cout8, ovf8} !== {8'h14, 1'b0, 1'b0}) begin
      $display("FAIL after_reset_op: got lat=%0d sum=%h cout=%b ovf=%b, want 9 14 0 0",
               lat, sum8, cout8, ovf8);
    end else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_random8();
    int lat, nb;
    longint es;
    bit eco, eov;
    logic [7:0] ra, rb;
    logic rc, rs;
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      model(8, longint'(ra), longint'(rb), rc, rs, es, eco, eov);
      op8(ra, rb, rc, rs, lat, nb);
      chk_cnt++;
      if (lat !== 9 || sum8 !== 8'(es) || cout8 !== eco || ovf8 !== eov) begin
        $display("FAIL random8 a=%h b=%h cin=%b sub=%b: got lat=%0d sum=%h cout=%b ovf=%b, want 9 %h %b %b",
                 ra, rb, rc, rs, lat, sum8, cout8, ovf8, 8'(es), eco, eov);
      end else pass_cnt++;
      // Randomly chain the next operation back-to-back or idle one cycle.
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_width2_sweep();
    int lat;
    longint es;
    bit eco, eov;
    logic [4:0] v;
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      model(2, longint'(v[4:3]), longint'(v[2:1]), v[0], 1'b0, es, eco, eov);
      if (i >= 0) begin
        // cin varies in bit 0; sub taken from the upper half of the sweep.
      end
      model(2, longint'(v[3:2]), longint'(v[1:0]), v[4] ? 1'b0 : v[0], v[4], es, eco, eov);
      op2(v[3:2], v[1:0], v[4] ? 1'b0 : v[0], v[4], lat);
      chk_cnt++;
      if (lat !== 3 || sum2 !== 2'(es) || cout2 !== eco || ovf2 !== eov) begin
        $display("FAIL width2 a=%0d b=%0d sub=%b: got lat=%0d sum=%0d cout=%b ovf=%b, want 3 %0d %b %b",
                 v[3:2], v[1:0], v[4], lat, sum2, cout2, ovf2, 2'(es), eco, eov);
      end else pass_cnt++;
      @(negedge clk);
    end
    // Subtract half with cin=1 presented, which must be ignored.
    for (int i = 0; i < 16; i++) begin
      v = 5'(i);
      model(2, longint'(v[3:2]), longint'(v[1:0]), 1'b1, 1'b1, es, eco, eov);
      op2(v[3:2], v[1:0], 1'b1, 1'b1, lat);
      chk_cnt++;
      if (lat !== 3 || sum2 !== 2'(es) || cout2 !== eco || ovf2 !== eov) begin
        $display("FAIL width2_sub_cin a=%0d b=%0d: got lat=%0d sum=%0d cout=%b ovf=%b, want 3 %0d %b %b",
                 v[3:2], v[1:0], lat, sum2, cout2, ovf2, 2'(es), eco, eov);
      end else pass_cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    chk_cnt = 0; pass_cnt = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0;
    test_reset();
    test_latency();
    test_carry_sub();
    test_back_to_back();
    test_start_ignored();
    test_async_reset();
    test_random8();
    @(negedge clk);
    test_width2_sweep();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
